crc32_stream_arbiter: RTL
=========================

Name: crc32_stream_arbiter

Overview:
- Shares one single-cycle CRC-32 word engine (poly 0x04C11DB7, MSB-first, non-reflected, 32 shifts per word) among N_REQ requesters.
- Each requester streams a multi-word message with valid/ready/last handshakes.
- A round-robin arbiter grants one requester at a time for a whole message and accumulates the running CRC.
- The block returns the CRC tagged with the requester ID over a valid/ready result port, between the packet sources and the checksum insertion stage.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- POLY, 32'h04C11DB7, CRC polynomial without the x^32 term.
- INIT, 32'h00000000, running-CRC value loaded at the start of each message.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester word valid
- req_data  in  32*N_REQ  per-requester data word; requester i uses bits [32*i+31:32*i]
- req_last  in  N_REQ  marks the final word of the message
- req_ready  out  N_REQ  word accepted when valid&ready
- res_valid  out  1  result available
- res_crc  out  32  message CRC
- res_id  out  $clog2(N_REQ)  requester that owns the result
- res_ready  in  1  result consumer ready

Behaviour:
- Reset values, applied synchronously on clk when rst=1, overriding everything including an active message:
  - outputs: req_ready=0, res_valid=0, res_crc=0, res_id=0
  - internal: state=IDLE, crc=INIT, last_grant=N_REQ-1, so requester 0 has top priority after reset.
  - A partial message is discarded; no result is produced for it.
- Step function:
  - step(x) = 32 iterations of: if x[31] then x=(x<<1)^POLY else x=x<<1.
  - Per accepted word: crc <= step(crc ^ word).
  - A single word W with INIT=0 gives step(W).
- State IDLE:
  - req_ready=0 for all requesters.
  - If any req_valid is set, grant the first requester with valid set, searching from last_grant+1 upward with wrap.
  - Register grant and set last_grant=grant. Load crc=INIT. Go to STREAM.
  - Arbitration takes exactly one cycle.
- State STREAM:
  - req_ready[grant]=1; all other req_ready bits are 0.
  - On req_valid[grant]: update crc.
  - If req_last[grant] is also set, go to RESULT with res_crc = the updated CRC.
  - If req_valid[grant] drops, stall with CRC held. The grant is held; there is no timeout.
  - Other requesters' valid signals are ignored until the message completes.
- State RESULT:
  - res_valid=1, res_crc and res_id stable while res_ready=0.
  - On res_valid&res_ready, go to IDLE.
  - req_ready=0 for all requesters in this state.
- Latency:
  - The last word is accepted at cycle t; res_valid=1 at cycle t+1.
  - The minimum message cost is 1 (IDLE) + words + 1 (result) cycles.
- Boundary cases:
  - A 1-word message has last on its first word.
  - A requester that is valid in IDLE but still valid after its result is completed gets no re-grant while others are waiting; round-robin forbids it.
  - If res_ready is already high when RESULT is entered, the handshake completes in one cycle.
- req_ready depends only on registered state (no valid→ready path). res_valid is registered.

Optional Feature:
- Macro: CRC32_FINAL_XOR_EN.
- Defined: res_crc = running CRC ^ 32'hFFFFFFFF, applied only at output. The running-CRC arithmetic is unchanged.
- Undefined: res_crc = running CRC unmodified.

Decomposition:
- Package crc32_pkg holds:
  - CRC32_POLY and CRC32_INIT constants
  - state enum typedef {IDLE, STREAM, RESULT}
  - function crc32_step(crc, word)
- One sub-module, crc32_word_step: combinational, takes crc_in and data_in and outputs crc_out = step(crc_in^data_in). The arbiter instantiates it once on the granted lane.

Test Plan:
- Single word: after reset, req0 sends 0x00000001 with last=1 → res_valid two cycles after valid is asserted, res_crc=0x04C11DB7, res_id=0; with CRC32_FINAL_XOR_EN, res_crc=0xFB3EE248.
- Two words: req1 sends 0x00000000 then 0x00000001 with last on the 2nd → res_crc=0x04C11DB7, res_id=1. Insert 3 idle cycles between the words → same result, req_ready[1] held high throughout.
- Round-robin: req0..req3 all valid with 1-word messages of 0x00000000 each → results in id order 0,1,2,3, each res_crc=0x00000000. Requester 0 re-asserting immediately is served only after requester 3.
- Backpressure: res_ready=0 for 5 cycles after res_valid → res_crc and res_id stable, all req_ready=0. On res_ready=1 the handshake completes in one cycle, followed by IDLE.
- Reset mid-message: req2 sends 2 words without last, assert rst for 1 cycle → all outputs 0, no result. A next message of 0x00000001 from req2 gives res_crc=0x04C11DB7 (init reloaded).
- Random traffic: random messages of 1–16 words across all requesters with random valid/res_ready gaps → every res_crc matches the reference model for its message, res_id matches the sender, and no lane other than the granted one sees ready.

Source files
------------

// File: rtl/crc32_pkg.sv
// Shared CRC-32 constants, arbiter state encoding and the reference word-step function.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT      = 32'h00000000;
  localparam logic [31:0] CRC32_XOR_MASK  = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    RESULT
  } state_e;

  // MSB-first, non-reflected: fold the word in, then 32 single-bit shifts.
  function automatic logic [31:0] crc32_step(
    input logic [31:0] crc,
    input logic [31:0] word,
    input logic [31:0] poly = CRC32_POLY
  );
    logic [31:0] x;
    x = crc ^ word;
    for (int i = 0; i < 32; i++) begin
      x = x[31] ? ((x << 1) ^ poly) : (x << 1);
    end
    return x;
  endfunction

endpackage

// File: rtl/crc32_word_step.sv
// Combinational single-cycle CRC-32 engine: crc_out = step(crc_in ^ data_in).
module crc32_word_step
  import crc32_pkg::*;
#(
  parameter logic [31:0] POLY = CRC32_POLY
) (
  input  logic [31:0] crc_in,
  input  logic [31:0] data_in,
  output logic [31:0] crc_out
);

  assign crc_out = crc32_step(crc_in, data_in, POLY);

endmodule

// File: rtl/crc32_stream_arbiter.sv
// Round-robin sharing of one CRC-32 word engine among N_REQ message streams.
// Optional macro CRC32_FINAL_XOR_EN inverts the reported CRC (running CRC unchanged).
module crc32_stream_arbiter
  import crc32_pkg::*;
#(
  parameter int          N_REQ = 4,
  parameter logic [31:0] POLY  = CRC32_POLY,
  parameter logic [31:0] INIT  = CRC32_INIT,
  localparam int         IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 res_valid,
  output logic [31:0]          res_crc,
  output logic [IDW-1:0]       res_id,
  input  logic                 res_ready
);

`ifdef CRC32_FINAL_XOR_EN
  localparam logic [31:0] OUT_MASK = CRC32_XOR_MASK;
`else
  localparam logic [31:0] OUT_MASK = 32'h00000000;
`endif

  state_e          state_q, state_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [31:0]     crc_q, crc_d;
  logic [31:0]     res_crc_q, res_crc_d;
  logic [IDW-1:0]  res_id_q, res_id_d;

  logic [31:0]     lane_data [N_REQ];
  logic [31:0]     step_out;
  logic            pick_found;
  logic [IDW-1:0]  pick_idx;
  logic [IDW-1:0]  scan_idx;

  // Ready is decoded from registered state only, so there is no valid-to-ready path.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign lane_data[gi] = req_data[32*gi +: 32];
    assign req_ready[gi] = (state_q == STREAM) && (grant_q == IDW'(gi));
  end

  crc32_word_step #(
    .POLY (POLY)
  ) u_step (
    .crc_in  (crc_q),
    .data_in (lane_data[grant_q]),
    .crc_out (step_out)
  );

  // First valid requester after last_grant, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_grant_q;
    scan_idx   = last_grant_q;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = IDW'((int'(last_grant_q) + k) % N_REQ);
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    crc_d        = crc_q;
    res_crc_d    = res_crc_q;
    res_id_d     = res_id_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          crc_d        = INIT;
          state_d      = STREAM;
        end
      end
      STREAM: begin
        if (req_valid[grant_q]) begin
          crc_d = step_out;
          if (req_last[grant_q]) begin
            res_crc_d = step_out ^ OUT_MASK;
            res_id_d  = grant_q;
            state_d   = RESULT;
          end
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDW'(N_REQ - 1);
      crc_q        <= INIT;
      res_crc_q    <= 32'h00000000;
      res_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      crc_q        <= crc_d;
      res_crc_q    <= res_crc_d;
      res_id_q     <= res_id_d;
    end
  end

  assign res_valid = (state_q == RESULT);
  assign res_crc   = res_crc_q;
  assign res_id    = res_id_q;

endmodule
